// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver: the received word, the
// frame-complete strobe and the frame-error strobe.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       frame_err;

   modport master (output rx_data, output rx_done_tick, output frame_err);
   modport slave  (input  rx_data, input  rx_done_tick, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
// A 2-flop synchronizer feeds a falling-edge detector and a
// START/DATA/STOP state machine. The start bit is re-checked at its middle
// to reject glitches. Data bits are sampled mid-bit, LSB first, and the word
// is right-justified in an 8-bit register. Completion happens at the middle
// of the last stop bit, which leaves half a bit of margin before the next
// start edge.
// Optional feature: define UART_RX_PARITY_EN to add a PARITY state that
// checks one even-parity bit after the data bits.
module uart_rx #(
   parameter int DATA_BIT = 8,
   parameter int STOP_BIT = 1
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      s_tick,
   input  logic      rx,
   uart_rx_if.master rx_bus
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BIT - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } state_t;
`endif

   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       done_q, done_d;
   logic       ferr_q, ferr_d;
   logic       stop_err_q, stop_err_d;
   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q, prev_d;
   logic       rx_s;
   logic       fall_s;
   logic       stop_err_cur_s;
   logic       par_err_s;

`ifdef UART_RX_PARITY_EN
   logic       par_err_q, par_err_d;
`endif

   assign rx_s   = sync2_q;
   assign fall_s = prev_q & ~sync2_q;

`ifdef UART_RX_PARITY_EN
   assign par_err_s = par_err_q;
`else
   assign par_err_s = 1'b0;
`endif

   assign rx_bus.rx_data      = rx_data_q;
   assign rx_bus.rx_done_tick = done_q;
   assign rx_bus.frame_err    = ferr_q;

   // Input synchronizer chain and previous-sample tracking for edge detection.
   always_comb begin
      sync1_d = rx;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Next-state, counter, shift-register and output strobe logic.
   always_comb begin
      state_d        = state_q;
      tick_d         = tick_q;
      bit_d          = bit_q;
      shift_d        = shift_q;
      rx_data_d      = rx_data_q;
      stop_err_d     = stop_err_q;
      done_d         = 1'b0;
      ferr_d         = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d      = par_err_q;
`endif
      // The stop bit is judged from the live sample on the first stop bit and
      // from the stored verdict on any later one.
      stop_err_cur_s = (bit_q == 3'd0) ? ~rx_s : stop_err_q;

      case (state_q)
         ST_IDLE: begin
            if (fall_s) begin
               state_d = ST_START;
               tick_d  = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if (s_tick) begin
               if (tick_q == 4'd7) begin
                  tick_d = 4'd0;
                  bit_d  = 3'd0;
                  if (!rx_s) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end else begin
               tick_d = tick_q;
            end
         end

         ST_DATA: begin
            if (s_tick) begin
               if (tick_q == 4'd15) begin
                  tick_d                = 4'd0;
                  // Shift right and insert the new bit at the top of the word
                  // so the finished word ends up right-justified.
                  shift_d               = {1'b0, shift_q[7:1]};
                  shift_d[DATA_BIT - 1] = rx_s;
                  if (bit_q == LAST_BIT) begin
                     bit_d      = 3'd0;
                     stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                     state_d    = ST_PARITY;
`else
                     state_d    = ST_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end else begin
               tick_d = tick_q;
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (s_tick) begin
               if (tick_q == 4'd15) begin
                  tick_d     = 4'd0;
                  bit_d      = 3'd0;
                  stop_err_d = 1'b0;
                  // Even parity: data bits plus parity bit must XOR to 0.
                  par_err_d  = (^shift_q) ^ rx_s;
                  state_d    = ST_STOP;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end else begin
               tick_d = tick_q;
            end
         end
`endif

         ST_STOP: begin
            if (s_tick) begin
               if (tick_q == 4'd15) begin
                  tick_d     = 4'd0;
                  stop_err_d = stop_err_cur_s;
                  if (bit_q == LAST_STOP) begin
                     state_d   = ST_IDLE;
                     bit_d     = 3'd0;
                     rx_data_d = shift_q;
                     done_d    = 1'b1;
                     ferr_d    = stop_err_cur_s | par_err_s;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end else begin
               tick_d = tick_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
         end
      endcase
   end

   // State, counters, datapath and output strobe registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tick_q     <= 4'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         rx_data_q  <= 8'd0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop_err_q <= 1'b0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
         stop_err_q <= stop_err_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
`ifdef UART_RX_PARITY_EN
         par_err_q  <= par_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (default parameters: 8 data bits, 1 stop bit).
// s_tick pulses every 4 clk, so one bit period is 64 clk.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   logic clk;
   logic reset;
   logic s_tick;
   logic rx;

   uart_rx_if bus ();

   uart_rx #(.DATA_BIT(8), .STOP_BIT(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .s_tick (s_tick),
      .rx     (rx),
      .rx_bus (bus.master)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Monitor state
   int         done_cnt = 0;
   logic [7:0] got_data [32];
   logic       got_err  [32];
   int         chg_viol = 0;
   int         orphan_err = 0;
   logic [7:0] prev_data = 8'd0;
   int         exp_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oversampling tick generator: one clk-wide pulse every 4 clk.
   int tick_div = 0;
   always @(negedge clk) begin
      tick_div = (tick_div + 1) % 4;
      s_tick   = (tick_div == 0);
   end

   // Record every completion and watch for illegal rx_data / frame_err activity.
   always @(negedge clk) begin
      if (bus.rx_done_tick) begin
         if (done_cnt < 32) begin
            got_data[done_cnt] <= bus.rx_data;
            got_err[done_cnt]  <= bus.frame_err;
         end
         done_cnt <= done_cnt + 1;
      end
      if (!reset && !bus.rx_done_tick && (bus.rx_data != prev_data))
         chg_viol <= chg_viol + 1;
      if (bus.frame_err && !bus.rx_done_tick)
         orphan_err <= orphan_err + 1;
      prev_data <= bus.rx_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold_bits(input logic v, input int nclk);
      rx = v;
      repeat (nclk) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
      hold_bits(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) hold_bits(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
      hold_bits(par_v, BIT_CLK);
`endif
      hold_bits(stop_v, BIT_CLK);
      rx = 1'b1;
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   initial begin
      logic [7:0] b81;
      rx     = 1'b1;
      s_tick = 1'b0;
      reset  = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("reset_rx_data", {24'd0, bus.rx_data}, 32'h0);
      check_eq("reset_done", {31'd0, bus.rx_done_tick}, 32'h0);
      check_eq("reset_ferr", {31'd0, bus.frame_err}, 32'h0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Single good frame
      send_frame(8'hA5, 1'b1, even_par(8'hA5));
      exp_cnt = 1;
      repeat (40) @(negedge clk);
      check_eq("a5_count", done_cnt, exp_cnt);
      check_eq("a5_data", {24'd0, got_data[0]}, 32'hA5);
      check_eq("a5_err", {31'd0, got_err[0]}, 32'h0);

      // Back-to-back frames
      send_frame(8'h3C, 1'b1, even_par(8'h3C));
      send_frame(8'hFF, 1'b1, even_par(8'hFF));
      exp_cnt = 3;
      repeat (40) @(negedge clk);
      check_eq("b2b_count", done_cnt, exp_cnt);
      check_eq("b2b_data0", {24'd0, got_data[1]}, 32'h3C);
      check_eq("b2b_err0", {31'd0, got_err[1]}, 32'h0);
      check_eq("b2b_data1", {24'd0, got_data[2]}, 32'hFF);
      check_eq("b2b_err1", {31'd0, got_err[2]}, 32'h0);

      // Bad stop bit
      send_frame(8'h55, 1'b0, even_par(8'h55));
      exp_cnt = 4;
      repeat (60) @(negedge clk);
      check_eq("badstop_count", done_cnt, exp_cnt);
      check_eq("badstop_data", {24'd0, got_data[3]}, 32'h55);
      check_eq("badstop_err", {31'd0, got_err[3]}, 32'h1);

      // Short glitch must be rejected, then a normal frame still works
      hold_bits(1'b0, 20);
      hold_bits(1'b1, 200);
      check_eq("glitch_count", done_cnt, exp_cnt);
      send_frame(8'h99, 1'b1, even_par(8'h99));
      exp_cnt = 5;
      repeat (40) @(negedge clk);
      check_eq("post_glitch_count", done_cnt, exp_cnt);
      check_eq("post_glitch_data", {24'd0, got_data[4]}, 32'h99);
      check_eq("post_glitch_err", {31'd0, got_err[4]}, 32'h0);

      // Reset during data bit 4 of 0x81, then 0x42
      b81 = 8'h81;
      hold_bits(1'b0, BIT_CLK);
      for (int i = 0; i < 4; i++) hold_bits(b81[i], BIT_CLK);
      hold_bits(b81[4], 30);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("midreset_rx_data", {24'd0, bus.rx_data}, 32'h0);
      check_eq("midreset_count", done_cnt, exp_cnt);
      send_frame(8'h42, 1'b1, even_par(8'h42));
      exp_cnt = 6;
      repeat (40 + 20 * BIT_CLK) @(negedge clk);
      check_eq("after_reset_count", done_cnt, exp_cnt);
      check_eq("after_reset_data", {24'd0, got_data[5]}, 32'h42);

      // Break: line low for 15 bit times gives exactly one errored frame
      hold_bits(1'b0, 15 * BIT_CLK);
      hold_bits(1'b1, 200);
      exp_cnt = 7;
      check_eq("break_count", done_cnt, exp_cnt);
      check_eq("break_data", {24'd0, got_data[6]}, 32'h0);
      check_eq("break_err", {31'd0, got_err[6]}, 32'h1);
      send_frame(8'h5A, 1'b1, even_par(8'h5A));
      exp_cnt = 8;
      repeat (40) @(negedge clk);
      check_eq("post_break_count", done_cnt, exp_cnt);
      check_eq("post_break_data", {24'd0, got_data[7]}, 32'h5A);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity bit 0 is wrong, parity bit 1 is right
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      exp_cnt = 10;
      repeat (40) @(negedge clk);
      check_eq("par_count", done_cnt, exp_cnt);
      check_eq("par_bad_data", {24'd0, got_data[8]}, 32'h07);
      check_eq("par_bad_err", {31'd0, got_err[8]}, 32'h1);
      check_eq("par_good_err", {31'd0, got_err[9]}, 32'h0);
`endif

      // rx_data holds across idle time
      repeat (300) @(negedge clk);
      check_eq("hold_rx_data", {24'd0, bus.rx_data}, {24'd0, got_data[exp_cnt - 1]});
      check_eq("rx_data_change_outside_done", chg_viol, 0);
      check_eq("ferr_without_done", orphan_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
